// File: rtl/pmem_loader.sv
// Byte-stream program loader: packs three received bytes into one 18-bit pmem word,
// drives the pmem write port, and holds the CPU in reset while a load is in progress.
module pmem_loader #(
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 8192,
    parameter int TIMEOUT   = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic              pmem_wen,
    output logic [17:0]       pmem_data,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] word_count
);

    typedef enum logic [2:0] {IDLE, B0, B1, B2, DONE, ERR} state_t;

    localparam int                TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]     T_LAST = TW'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       MAX_W  = 32'(MAX_WORDS);

    state_t        state, state_nxt;
    logic [TW-1:0] tcnt;
    logic [7:0]    lo, mid;
    logic          accept, wr_go, t_inc, full;

    // Compared at 32 bits so MAX_WORDS == 2**ADDR_W cannot alias to zero.
    assign full = (32'(word_count) == MAX_W);

    assign busy    = (state == B0) || (state == B1) || (state == B2);
    assign done    = (state == DONE);
    assign err     = (state == ERR);
    assign cpu_rst = busy | err;

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_nxt = state;
        accept    = 1'b0;
        wr_go     = 1'b0;
        t_inc     = 1'b0;
        if (load_start) begin
            state_nxt = B0;
        end else begin
            case (state)
                B0: if (rx_valid) begin
                    accept    = 1'b1;
                    state_nxt = B1;
                end
                B1: if (rx_valid) begin
                    accept    = 1'b1;
                    state_nxt = B2;
                end else if (tcnt == T_LAST) begin
                    state_nxt = ERR;
                end else begin
                    t_inc = 1'b1;
                end
                B2: if (rx_valid) begin
                    accept = 1'b1;
                    case (rx_data[7:2])
                        6'b000000: if (full) state_nxt = ERR;
                                   else begin
                                       wr_go     = 1'b1;
                                       state_nxt = B0;
                                   end
                        6'b111111: state_nxt = DONE;
                        default:   state_nxt = ERR;
                    endcase
                end else if (tcnt == T_LAST) begin
                    state_nxt = ERR;
                end else begin
                    t_inc = 1'b1;
                end
                default: state_nxt = state;
            endcase
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pmem_addr  <= BASE;
            pmem_wen   <= 1'b0;
            pmem_data  <= '0;
            word_count <= '0;
            tcnt       <= '0;
            lo         <= '0;
            mid        <= '0;
        end else begin
            state    <= state_nxt;
            pmem_wen <= wr_go;
            if (wr_go)
                pmem_data <= {rx_data[1:0], mid, lo};

            // The address advances the cycle after the write pulse; a restart wins.
            if (load_start) begin
                pmem_addr  <= BASE;
                word_count <= '0;
                lo         <= '0;
                mid        <= '0;
            end else begin
                if (pmem_wen) begin
                    pmem_addr  <= pmem_addr + 1'b1;
                    word_count <= word_count + 1'b1;
                end
                if (accept && state == B0) lo  <= rx_data;
                if (accept && state == B1) mid <= rx_data;
            end

            if (load_start || accept)
                tcnt <= '0;
            else if (t_inc)
                tcnt <= tcnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pmem_loader.sv
// Directed bench for pmem_loader: a per-cycle vector table for the main load flow,
// plus hand-written sequences for timeout, capacity overflow and mid-load reset.
module tb_pmem_loader;

    localparam int AW   = 16;
    localparam int MAXW = 4;
    localparam int TOUT = 20;

    logic          clk = 1'b0;
    logic          rst, load_start, rx_valid;
    logic [7:0]    rx_data;
    logic [AW-1:0] pmem_addr, word_count;
    logic          pmem_wen, cpu_rst, busy, done, err;
    logic [17:0]   pmem_data;

    int total = 0;
    int bad   = 0;
    int wen_cnt = 0;
    logic [AW+17:0] wlog[$];

    always #5 clk = ~clk;

    pmem_loader #(.ADDR_W(AW), .BASE_ADDR(0), .MAX_WORDS(MAXW), .TIMEOUT(TOUT)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .rx_valid(rx_valid),
        .rx_data(rx_data), .pmem_addr(pmem_addr), .pmem_wen(pmem_wen),
        .pmem_data(pmem_data), .cpu_rst(cpu_rst), .busy(busy), .done(done),
        .err(err), .word_count(word_count)
    );

    always @(negedge clk) begin
        if (pmem_wen) begin
            wen_cnt++;
            wlog.push_back({pmem_addr, pmem_data});
        end
    end

    typedef struct {
        logic st, rv, r;
        logic [7:0] d;
        logic wen; logic [15:0] addr; logic [17:0] data;
        logic bsy, dn, er, cpu; logic [15:0] wc;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input logic st, input logic rv, input logic [7:0] d, input logic r);
        @(negedge clk);
        load_start = st; rx_valid = rv; rx_data = d; rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 8'h00, 0);
    endtask

    task automatic add(input logic st, input logic rv, input logic [7:0] d, input logic r,
                       input logic wen, input logic [15:0] addr, input logic [17:0] data,
                       input logic bsy, input logic dn, input logic er, input logic cpu,
                       input logic [15:0] wc);
        vec_t v;
        v.st = st; v.rv = rv; v.d = d; v.r = r; v.wen = wen; v.addr = addr; v.data = data;
        v.bsy = bsy; v.dn = dn; v.er = er; v.cpu = cpu; v.wc = wc;
        vecs.push_back(v);
    endtask

    function automatic logic [63:0] outs();
        return 64'({pmem_wen, pmem_addr, pmem_data, busy, done, err, cpu_rst, word_count});
    endfunction

    initial begin
        rst = 1'b1; load_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

        //   st rv data  r   wen addr  data      bsy dn er cpu wc
        add(0, 0, 8'h00, 1,  0, 16'd0, 18'h00000, 0, 0, 0, 0, 16'd0); // reset
        add(0, 1, 8'hAA, 0,  0, 16'd0, 18'h00000, 0, 0, 0, 0, 16'd0); // byte in IDLE ignored
        add(1, 0, 8'h00, 0,  0, 16'd0, 18'h00000, 1, 0, 0, 1, 16'd0);
        add(0, 1, 8'h34, 0,  0, 16'd0, 18'h00000, 1, 0, 0, 1, 16'd0);
        add(0, 0, 8'h00, 0,  0, 16'd0, 18'h00000, 1, 0, 0, 1, 16'd0);
        add(0, 1, 8'h12, 0,  0, 16'd0, 18'h00000, 1, 0, 0, 1, 16'd0);
        add(0, 1, 8'h02, 0,  1, 16'd0, 18'h21234, 1, 0, 0, 1, 16'd0); // write pulse
        add(0, 0, 8'h00, 0,  0, 16'd1, 18'h21234, 1, 0, 0, 1, 16'd1);
        add(0, 1, 8'h78, 0,  0, 16'd1, 18'h21234, 1, 0, 0, 1, 16'd1);
        add(0, 1, 8'h56, 0,  0, 16'd1, 18'h21234, 1, 0, 0, 1, 16'd1);
        add(0, 1, 8'h01, 0,  1, 16'd1, 18'h15678, 1, 0, 0, 1, 16'd1);
        add(0, 1, 8'hBC, 0,  0, 16'd2, 18'h15678, 1, 0, 0, 1, 16'd2); // lo on wen cycle
        add(0, 1, 8'h9A, 0,  0, 16'd2, 18'h15678, 1, 0, 0, 1, 16'd2);
        add(0, 1, 8'h03, 0,  1, 16'd2, 18'h39ABC, 1, 0, 0, 1, 16'd2);
        add(0, 1, 8'h00, 0,  0, 16'd3, 18'h39ABC, 1, 0, 0, 1, 16'd3);
        add(0, 1, 8'h00, 0,  0, 16'd3, 18'h39ABC, 1, 0, 0, 1, 16'd3);
        add(0, 1, 8'hFC, 0,  0, 16'd3, 18'h39ABC, 0, 1, 0, 0, 16'd3); // end marker
        add(0, 1, 8'h11, 0,  0, 16'd3, 18'h39ABC, 0, 1, 0, 0, 16'd3);
        add(1, 1, 8'h55, 0,  0, 16'd0, 18'h39ABC, 1, 0, 0, 1, 16'd0); // start wins, byte dropped
        add(0, 1, 8'h44, 0,  0, 16'd0, 18'h39ABC, 1, 0, 0, 1, 16'd0);
        add(0, 1, 8'h33, 0,  0, 16'd0, 18'h39ABC, 1, 0, 0, 1, 16'd0);
        add(0, 1, 8'h00, 0,  1, 16'd0, 18'h03344, 1, 0, 0, 1, 16'd0);
        add(0, 0, 8'h00, 0,  0, 16'd1, 18'h03344, 1, 0, 0, 1, 16'd1);
        add(0, 1, 8'h01, 0,  0, 16'd1, 18'h03344, 1, 0, 0, 1, 16'd1);
        add(0, 1, 8'h02, 0,  0, 16'd1, 18'h03344, 1, 0, 0, 1, 16'd1);
        add(0, 1, 8'h40, 0,  0, 16'd1, 18'h03344, 0, 0, 1, 1, 16'd1); // bad tag
        add(0, 1, 8'h00, 0,  0, 16'd1, 18'h03344, 0, 0, 1, 1, 16'd1);

        foreach (vecs[i]) begin
            tick(vecs[i].st, vecs[i].rv, vecs[i].d, vecs[i].r);
            check($sformatf("vec%0d", i), outs(),
                  64'({vecs[i].wen, vecs[i].addr, vecs[i].data, vecs[i].bsy, vecs[i].dn,
                       vecs[i].er, vecs[i].cpu, vecs[i].wc}));
        end
        check("wen_count_table", 64'(wen_cnt), 64'd4);
        check("log0", 64'(wlog[0]), 64'({16'd0, 18'h21234}));
        check("log1", 64'(wlog[1]), 64'({16'd1, 18'h15678}));
        check("log2", 64'(wlog[2]), 64'({16'd2, 18'h39ABC}));
        check("log3", 64'(wlog[3]), 64'({16'd0, 18'h03344}));

        // Timeout: a byte restarts the count, then TOUT silent cycles end the load.
        tick(1, 0, 8'h00, 0);
        idle(50);
        check("b0_no_timeout", 64'({busy, err}), 64'b10);
        tick(0, 1, 8'h01, 0);
        idle(TOUT - 5);
        tick(0, 1, 8'h02, 0);
        idle(TOUT - 1);
        check("pre_timeout", 64'({busy, err, cpu_rst}), 64'b101);
        idle(1);
        check("timeout_err", 64'({busy, err, cpu_rst}), 64'b011);
        check("timeout_nowrite", 64'(wen_cnt), 64'd4);
        tick(1, 0, 8'h00, 0);
        check("start_clears_err", 64'({busy, done, err}), 64'b100);

        // Capacity: MAXW words fit, the next data word is rejected.
        for (int w = 0; w < MAXW; w++) begin
            tick(0, 1, 8'(w), 0);
            tick(0, 1, 8'h00, 0);
            tick(0, 1, 8'h00, 0);
            idle(1);
        end
        check("full_count", 64'({word_count, pmem_addr}), 64'({16'd4, 16'd4}));
        tick(0, 1, 8'h05, 0);
        tick(0, 1, 8'h00, 0);
        tick(0, 1, 8'h00, 0);
        idle(1);
        check("overflow_err", 64'({busy, err, cpu_rst}), 64'b011);
        check("overflow_nowrite", 64'(wen_cnt), 64'd8);
        check("last_write", 64'(wlog[$]), 64'({16'd3, 18'h00003}));

        // Reset sampled together with the third byte cancels the pending write.
        tick(1, 0, 8'h00, 0);
        tick(0, 1, 8'h01, 0);
        tick(0, 1, 8'h02, 0);
        tick(0, 1, 8'h00, 1);
        check("rst_outputs", outs(), 64'd0);
        tick(0, 0, 8'h00, 0);
        check("rst_no_wen", 64'({pmem_wen, cpu_rst}), 64'd0);
        check("rst_wen_count", 64'(wen_cnt), 64'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
